// File: rtl/multichannel_demodulator.sv
// Multi-channel pulse demodulator: each channel turns a trigger into a pulse of
// programmable width, optionally followed by a holdoff interval, with sticky miss flags.
module multichannel_demodulator #(
  parameter int CHANNELS = 4,
  parameter int CTR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic [CHANNELS-1:0]   in,
  input  logic [CTR_BITS-1:0]   pulse_width,
  input  logic [CTR_BITS-1:0]   holdoff,
  input  logic                  edge_mode,
  input  logic                  retrigger,
  input  logic                  miss_clear,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   miss,
  output logic [2*CHANNELS-1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } chan_state_t;

  logic [CHANNELS-1:0] in_q;
  logic [CHANNELS-1:0] trig;
  logic [CTR_BITS-1:0] pw_last;
  logic [CTR_BITS-1:0] ho_last;
  logic                pw_zero;
  logic                ho_zero;

  // in_q resets to all ones so a line already high at reset release is not an edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      in_q <= '1;
    end else begin
      in_q <= in;
    end
  end

  assign trig    = edge_mode ? (in & ~in_q) : in;
  assign pw_zero = (pulse_width == '0);
  assign ho_zero = (holdoff == '0);
  assign pw_last = pulse_width - 1'b1;
  assign ho_last = holdoff - 1'b1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    chan_state_t         state;
    logic [CTR_BITS-1:0] ctr;
    logic                miss_r;

    // miss_clear is applied first so a set in the same cycle overrides it.
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        state  <= ST_IDLE;
        ctr    <= '0;
        miss_r <= 1'b0;
      end else begin
        if (miss_clear) begin
          miss_r <= 1'b0;
        end
        if (!enable) begin
          state <= ST_IDLE;
          ctr   <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (trig[i] && !pw_zero) begin
                state <= ST_PULSE;
                ctr   <= '0;
              end
            end
            ST_PULSE: begin
              if (trig[i] && retrigger) begin
                ctr <= '0;
              end else begin
                if (trig[i] && edge_mode) begin
                  miss_r <= 1'b1;
                end
                if (pw_zero || ctr >= pw_last) begin
                  ctr   <= '0;
                  state <= ho_zero ? ST_IDLE : ST_HOLDOFF;
                end else begin
                  ctr <= ctr + 1'b1;
                end
              end
            end
            ST_HOLDOFF: begin
              if (trig[i]) begin
                miss_r <= 1'b1;
              end
              // A holdoff shrunk to zero mid-interval ends the interval at once.
              if (ho_zero || ctr >= ho_last) begin
                state <= ST_IDLE;
                ctr   <= '0;
              end else begin
                ctr <= ctr + 1'b1;
              end
            end
            default: begin
              state <= ST_IDLE;
              ctr   <= '0;
            end
          endcase
        end
      end
    end

    assign out[i]            = (state == ST_PULSE);
    assign busy[i]           = (state != ST_IDLE);
    assign miss[i]           = miss_r;
    assign state_dbg[2*i +: 2] = state;
  end

endmodule

// File: doc/multichannel_demodulator.md
Name: multichannel_demodulator

Overview:
- Parametrised, multi-channel pulse demodulator for the test harness: each channel turns a trigger on its input into an output pulse of programmable width, optionally followed by a holdoff (dead-time) interval.
- Adds edge- or level-trigger selection, retriggering, holdoff, per-channel busy status and sticky missed-trigger flags.
- Sits between the channel input pins/delay-line taps and the UART result capture; shared configuration comes from the UART register fields.

Parameters:
CHANNELS, 4, number of independent channels
CTR_BITS, 16, width of pulse_width, holdoff and the per-channel counters

Ports:
clk  input  1  system clock
n_reset  input  1  reset, asynchronous, active-low
enable  input  1  global enable; low forces all channels idle
in  input  CHANNELS  per-channel trigger inputs, synchronous to clk
pulse_width  input  CTR_BITS  output pulse length in clk cycles, shared by all channels
holdoff  input  CTR_BITS  dead-time after each pulse in cycles, shared; 0 means none
edge_mode  input  1  1 = trigger on rising edge of in; 0 = trigger while in is high
retrigger  input  1  1 = a trigger during a pulse restarts that channel's pulse
miss_clear  input  1  synchronous clear of all miss flags
out  output  CHANNELS  demodulated pulse per channel
busy  output  CHANNELS  channel not idle (pulse or holdoff)
miss  output  CHANNELS  sticky: a trigger was dropped on that channel

Behaviour:
- Reset: clk and n_reset as named above. The asynchronous, active-low reset takes effect immediately without a clock edge.
  - All channels go to IDLE; counters = 0; out = 0; busy = 0; miss = 0.
  - in_q (the previous-sample register) = all ones, so an input already held high at reset release does not trigger in edge mode.
- Trigger per channel:
  - trig[i] = edge_mode ? (in[i] & ~in_q[i]) : in[i].
  - in_q is updated every cycle, including while enable is low.
- Per-channel states are IDLE, PULSE and HOLDOFF. out[i] = (state == PULSE); busy[i] = (state != IDLE). Both are decoded from registered state.
- IDLE:
  - trig && enable && pulse_width != 0 -> PULSE, ctr = 0.
  - With pulse_width == 0, triggers are ignored and do not set miss.
- PULSE:
  - If pulse_width == 0 or ctr >= pulse_width-1, exit to HOLDOFF (ctr = 0) when holdoff != 0, otherwise to IDLE.
  - Otherwise ctr = ctr + 1.
  - trig && retrigger: ctr = 0 and the channel stays in PULSE; retrigger takes priority over exit.
  - trig && !retrigger && edge_mode: set miss.
  - Level mode without retrigger never sets miss while in PULSE.
- HOLDOFF:
  - ctr >= holdoff-1 -> IDLE; otherwise ctr + 1.
  - Any trig sets miss, including on the final holdoff cycle; IDLE accepts triggers from the next cycle.
- Latency: trigger sampled at edge k -> out high from k+1 for exactly pulse_width cycles (no retrigger). Holdoff occupies the following holdoff cycles.
- Live parameters: pulse_width and holdoff are compared every cycle, not latched.
  - Shrinking a parameter below the current ctr ends that phase on the next edge.
  - The counter cannot overflow: maximum ctr value is 2^CTR_BITS-2.
- enable low: every channel returns to IDLE on the next edge and out drops. miss is retained. Triggers are not acted on and do not set miss.
- miss_clear and a new miss on the same edge: set wins, flag stays 1.
- Channels are fully independent; simultaneous triggers on all channels behave identically.

Test Plan:
- CHANNELS=4, CTR_BITS=8, level mode, pw=5, holdoff=0; in[0] high for one cycle sampled at edge 10 -> out[0] high on cycles 11-15, low at 16; out[3:1] = 0; busy[0] matches out[0].
- Edge mode, pw=3, holdoff=4, retrigger=0; in[1] rises at edges 0 and 2 -> out[1] high on cycles 1-3; busy[1] high on 1-7; miss[1] = 1 from cycle 3; IDLE at 8; a rise at edge 7 also sets miss, a rise at edge 8 starts a new pulse at cycle 9.
- Edge mode, pw=4, retrigger=1; rises at edges 0 and 3 -> out[2] continuously high on cycles 1-7, miss[2] stays 0; level mode with in held high for 10 cycles -> out high throughout, dropping pw cycles after in falls.
- pw=0: pulses on all inputs -> out = 0, busy = 0, miss = 0. Set pw=1 -> each trigger gives a single-cycle out. Drop pw from 200 to 2 mid-pulse -> the pulse ends on the next edge.
- Assert n_reset mid-pulse between clock edges -> out, busy and miss go to 0 immediately. Release with in[0] held high: edge mode gives no pulse; level mode gives a pulse one cycle after the first sampled edge.
- miss_clear asserted on the same edge as a new holdoff trigger -> miss stays 1, and a clear on the next edge -> 0. enable deasserted during a pulse -> out low on the next edge and miss retained.
